// File: rtl/mult_decomp_seq.sv
// Sequential decomposed multiplier: one SUBxSUB sub-product per cycle over N*N cycles.
// Optional result self-check enabled by defining MULT_DECOMP_SELFCHECK_EN.
module mult_decomp_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SUB   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned N   = WIDTH / SUB;
  localparam int unsigned NN  = N * N;
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned SW2 = 2 * SUB;
  localparam int unsigned CW  = (NN > 1) ? $clog2(NN) : 1;
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;

  if ((SUB == 0) || (WIDTH < SUB) || ((WIDTH % SUB) != 0)) begin : g_bad_cfg
    $error("mult_decomp_seq: WIDTH must be a nonzero multiple of SUB");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   acc_d;

  logic [IW-1:0]   idx_i;
  logic [IW-1:0]   idx_j;
  logic [SUB-1:0]  a_chunk;
  logic [SUB-1:0]  b_chunk;
  logic [SW2-1:0]  sub_prod;
  logic            last;

  // Chunk selection and the shared sub-multiplier feeding the accumulator.
  always_comb begin
    idx_i    = IW'(32'(count_q) / N);
    idx_j    = IW'(32'(count_q) % N);
    a_chunk  = SUB'(a_q >> (SUB * 32'(idx_i)));
    b_chunk  = SUB'(b_q >> (SUB * 32'(idx_j)));
    sub_prod = SW2'(a_chunk) * SW2'(b_chunk);
    acc_d    = acc_q + (PW'(sub_prod) << (SUB * (32'(idx_i) + 32'(idx_j))));
    last     = (count_q == CW'(NN - 1));
  end

`ifdef MULT_DECOMP_SELFCHECK_EN
  logic [PW-1:0] ref_prod;
  logic          err_q;
  assign ref_prod = PW'(a_q) * PW'(b_q);
  assign err      = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      P         <= '0;
      busy      <= 1'b0;
`ifdef MULT_DECOMP_SELFCHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            acc_q    <= '0;
            count_q  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= CALC;
`ifdef MULT_DECOMP_SELFCHECK_EN
            err_q    <= 1'b0;
`endif
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (last) begin
            P         <= acc_d;
            out_valid <= 1'b1;
            count_q   <= '0;
            state_q   <= DONE;
`ifdef MULT_DECOMP_SELFCHECK_EN
            if (acc_d != ref_prod) err_q <= 1'b1;
`endif
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        DONE: begin
          // Drain returns to IDLE; acceptance waits for the following cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
